// File: rtl/mem_bus_xbar_if.sv
// ---------------------------------------------------------------------------
// mem_bus_xbar_if
//   Bundles every signal of the picorv32 native memory bus that passes through
//   the mem_bus_xbar interconnect. The interconnect has two sides:
//     - an upstream master side (one core): mem_valid/ready/addr/wdata/wstrb/rdata
//     - a downstream slave side (N_SLAVES devices): one-hot s_mem_valid,
//       per-slave s_mem_ready and s_mem_rdata, and a broadcast request copy.
//
//   Modports:
//     master : the environment around the interconnect (the core plus the
//              slave devices). It drives the request and the slave responses.
//     slave  : the interconnect itself. It answers the core and drives the
//              downstream selects and request copy.
// ---------------------------------------------------------------------------
interface mem_bus_xbar_if #(
  parameter int N_SLAVES = 4
) ();

  // Upstream (core) side
  logic                     mem_valid;
  logic                     mem_ready;
  logic [31:0]              mem_addr;
  logic [31:0]              mem_wdata;
  logic [3:0]               mem_wstrb;
  logic [31:0]              mem_rdata;

  // Downstream (slave) side; slave i owns s_mem_rdata[32*i+31:32*i]
  logic [N_SLAVES-1:0]      s_mem_valid;
  logic [N_SLAVES-1:0]      s_mem_ready;
  logic [N_SLAVES*32-1:0]   s_mem_rdata;
  logic [31:0]              s_mem_addr;
  logic [31:0]              s_mem_wdata;
  logic [3:0]               s_mem_wstrb;

  modport master (
    output mem_valid, mem_addr, mem_wdata, mem_wstrb,
    output s_mem_ready, s_mem_rdata,
    input  mem_ready, mem_rdata,
    input  s_mem_valid, s_mem_addr, s_mem_wdata, s_mem_wstrb
  );

  modport slave (
    input  mem_valid, mem_addr, mem_wdata, mem_wstrb,
    input  s_mem_ready, s_mem_rdata,
    output mem_ready, mem_rdata,
    output s_mem_valid, s_mem_addr, s_mem_wdata, s_mem_wstrb
  );

endinterface : mem_bus_xbar_if

// File: rtl/mem_bus_xbar.sv
// ---------------------------------------------------------------------------
// mem_bus_xbar
//   1-master / N-slave interconnect for the picorv32 native memory interface.
//
//   A request is decoded once, in IDLE, on addr[31:28]:
//     - ERR_REGION           -> internal status window (STAT)
//     - claimed by a slave   -> the lowest-index claiming slave is latched and
//                               driven through ACTIVE until it answers or the
//                               per-transaction timer expires
//     - anything else        -> error response (ERR), writes discarded
//
//   Every output is a register. The response phase of RESP/ERR/STAT takes two
//   cycles: the first loads mem_rdata (and any status update), the second
//   presents mem_ready for exactly one cycle and returns to IDLE. This keeps
//   mem_ready confined to those three states and gives a latency of 3 cycles
//   for a slave that accepts in its first selected cycle and 2 cycles for an
//   error or status access.
//
//   Status window (addr[31:28] == ERR_REGION, offset = addr[27:0]):
//     0x0 read : {16'b0, err_cnt[7:0], 6'b0, timeout_bit, err_bit}
//     0x0 write: wstrb[0] && wdata[0] clears err_bit, timeout_bit, err_cnt
//     0x4 read : last_err_addr
//     other    : reads 0
//
//   Ports:
//     clk      clock
//     rst_n    synchronous active-low reset
//     bus      mem_bus_xbar_if.slave (core side + slave side, see interface)
//     err_irq  level interrupt, mirrors the sticky error bit
// ---------------------------------------------------------------------------
module mem_bus_xbar #(
  parameter int                     N_SLAVES    = 4,
  parameter logic [N_SLAVES*16-1:0] SLV_REGIONS = {4{16'h0000}},
  parameter int                     TIMEOUT     = 1024,
  parameter logic [3:0]             ERR_REGION  = 4'hF,
  parameter logic [31:0]            ERR_RDATA   = 32'hDEAD_BEEF
) (
  input  logic          clk,
  input  logic          rst_n,
  mem_bus_xbar_if.slave bus,
  output logic          err_irq
);

  localparam int SEL_W = (N_SLAVES > 1) ? $clog2(N_SLAVES) : 1;
  localparam int TMR_W = $clog2(TIMEOUT) + 1;

  typedef enum logic [2:0] {
    IDLE,
    ACTIVE,
    RESP,
    ERR,
    STAT
  } state_e;

  // -------------------------------------------------------------------------
  // State and registered outputs
  // -------------------------------------------------------------------------
  state_e              state_q;
  logic                mem_ready_q;
  logic [31:0]         mem_rdata_q;
  logic [N_SLAVES-1:0] s_valid_q;
  logic [31:0]         addr_q;
  logic [31:0]         wdata_q;
  logic [3:0]          wstrb_q;
  logic [SEL_W-1:0]    sel_q;
  logic [TMR_W-1:0]    timer_q;

  // Status window
  logic                err_bit_q;
  logic                to_bit_q;
  logic [7:0]          err_cnt_q;
  logic [31:0]         last_err_addr_q;

  // -------------------------------------------------------------------------
  // Combinational helpers
  // -------------------------------------------------------------------------
  logic                hit;
  logic [SEL_W-1:0]    hit_idx;
  logic                slv_ready;
  logic [31:0]         slv_rdata;
  logic                to_evt;
  logic                err_evt;
  logic                stat_clr;
  logic [31:0]         stat_rdata;

  // Address decode: scanning from the top index down lets the lowest
  // claiming slave overwrite any higher one, so overlaps resolve to it.
  always_comb begin
    // NOTE: every variable written here gets a default first, otherwise a
    // path that skips the assignment would infer a latch.
    hit     = 1'b0;
    hit_idx = '0;
    for (int i = N_SLAVES - 1; i >= 0; i--) begin
      if (SLV_REGIONS[i*16 + int'(bus.mem_addr[31:28])]) begin
        hit     = 1'b1;
        hit_idx = SEL_W'(i);
      end
    end
  end

  // Response mux for the latched slave only; other slaves' ready/rdata are
  // never looked at, so a stray ready from a deselected slave is harmless.
  always_comb begin
    slv_ready = 1'b0;
    slv_rdata = '0;
    for (int i = 0; i < N_SLAVES; i++) begin
      if (sel_q == SEL_W'(i)) begin
        slv_ready = bus.s_mem_ready[i];
        slv_rdata = bus.s_mem_rdata[i*32 +: 32];
      end
    end
  end

  always_comb begin
    // Ready wins over a timeout landing in the same cycle.
    to_evt   = (state_q == ACTIVE) && !slv_ready &&
               (timer_q == TMR_W'(TIMEOUT - 1));
    // Events and clears fire only in the first (load) phase of their state.
    err_evt  = (state_q == ERR) && !mem_ready_q;
    stat_clr = (state_q == STAT) && !mem_ready_q &&
               (bus.mem_addr[27:0] == 28'h0) &&
               bus.mem_wstrb[0] && bus.mem_wdata[0];

    case (bus.mem_addr[27:0])
      28'h0:   stat_rdata = {16'h0, err_cnt_q, 6'b0, to_bit_q, err_bit_q};
      28'h4:   stat_rdata = last_err_addr_q;
      default: stat_rdata = 32'h0;
    endcase
  end

  // -------------------------------------------------------------------------
  // FSM with registered outputs
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q         <= IDLE;
      mem_ready_q     <= 1'b0;
      mem_rdata_q     <= '0;
      s_valid_q       <= '0;
      addr_q          <= '0;
      wdata_q         <= '0;
      wstrb_q         <= '0;
      sel_q           <= '0;
      timer_q         <= '0;
      err_bit_q       <= 1'b0;
      to_bit_q        <= 1'b0;
      err_cnt_q       <= '0;
      last_err_addr_q <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every
      // register samples the pre-edge value of every other register.
      case (state_q)
        IDLE: begin
          mem_ready_q <= 1'b0;
          if (bus.mem_valid) begin
            if (bus.mem_addr[31:28] == ERR_REGION) begin
              state_q <= STAT;
            end else if (hit) begin
              addr_q    <= bus.mem_addr;
              wdata_q   <= bus.mem_wdata;
              wstrb_q   <= bus.mem_wstrb;
              sel_q     <= hit_idx;
              timer_q   <= '0;
              s_valid_q <= N_SLAVES'(1) << hit_idx;
              state_q   <= ACTIVE;
            end else begin
              state_q <= ERR;
            end
          end
        end

        ACTIVE: begin
          timer_q <= timer_q + 1'b1;
          if (slv_ready) begin
            mem_rdata_q <= slv_rdata;
            s_valid_q   <= '0;
            state_q     <= RESP;
          end else if (to_evt) begin
            mem_rdata_q     <= ERR_RDATA;
            last_err_addr_q <= addr_q;
            s_valid_q       <= '0;
            state_q         <= RESP;
          end
        end

        RESP: begin
          if (!mem_ready_q) begin
            mem_ready_q <= 1'b1;
          end else begin
            mem_ready_q <= 1'b0;
            state_q     <= IDLE;
          end
        end

        ERR: begin
          if (!mem_ready_q) begin
            mem_rdata_q     <= ERR_RDATA;
            last_err_addr_q <= bus.mem_addr;
            mem_ready_q     <= 1'b1;
          end else begin
            mem_ready_q <= 1'b0;
            state_q     <= IDLE;
          end
        end

        STAT: begin
          if (!mem_ready_q) begin
            // A clearing write returns the pre-clear status word.
            mem_rdata_q <= stat_rdata;
            mem_ready_q <= 1'b1;
          end else begin
            mem_ready_q <= 1'b0;
            state_q     <= IDLE;
          end
        end

        default: begin
          mem_ready_q <= 1'b0;
          s_valid_q   <= '0;
          state_q     <= IDLE;
        end
      endcase

      // Sticky status; a clear beats an event in the same cycle.
      if (stat_clr) begin
        err_bit_q <= 1'b0;
        to_bit_q  <= 1'b0;
        err_cnt_q <= '0;
      end else if (err_evt || to_evt) begin
        err_bit_q <= 1'b1;
        if (to_evt) begin
          to_bit_q <= 1'b1;
        end
        if (err_cnt_q != 8'hFF) begin
          err_cnt_q <= err_cnt_q + 8'd1;
        end
      end
    end
  end

  // -------------------------------------------------------------------------
  // Output drive
  // -------------------------------------------------------------------------
  assign bus.mem_ready   = mem_ready_q;
  assign bus.mem_rdata   = mem_rdata_q;
  assign bus.s_mem_valid = s_valid_q;
  assign bus.s_mem_addr  = addr_q;
  assign bus.s_mem_wdata = wdata_q;
  assign bus.s_mem_wstrb = wstrb_q;
  assign err_irq         = err_bit_q;

endmodule : mem_bus_xbar
